// File: rtl/seven_seg_scanner_if.sv
// Datapath-to-scanner bundle: hex value, blank mask and load strobe in; segment/anode pins and status out.
// The decimal-point signals exist only when SEVEN_SEG_SCANNER_DP_EN is defined.
interface seven_seg_scanner_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          seven_seg;
    logic [DIGITS-1:0]   an;
    logic                frame_done;
    logic                pending;
`ifdef SEVEN_SEG_SCANNER_DP_EN
    logic [DIGITS-1:0]   dp;
    logic                dp_n;

    modport master (
        output value, load, blank, dp,
        input  seven_seg, an, frame_done, pending, dp_n
    );
    modport slave (
        input  value, load, blank, dp,
        output seven_seg, an, frame_done, pending, dp_n
    );
`else
    modport master (
        output value, load, blank,
        input  seven_seg, an, frame_done, pending
    );
    modport slave (
        input  value, load, blank,
        output seven_seg, an, frame_done, pending
    );
`endif
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous shadow loading.
// Optional decimal point: define SEVEN_SEG_SCANNER_DP_EN.
module seven_seg_scanner #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    seven_seg_scanner_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       psc_q, psc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pval_q, pval_d, aval_q, aval_d;
    logic [DIGITS-1:0]   pblk_q, pblk_d, ablk_q, ablk_d;
    logic                pend_q, pend_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q;
    logic                tick, wrap;
    logic [3:0]          nib;
`ifdef SEVEN_SEG_SCANNER_DP_EN
    logic [DIGITS-1:0]   pdp_q, pdp_d, adp_q, adp_d;
    logic                dpn_q, dpn_d;
`endif

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    assign tick = (psc_q == PW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx_q == IW'(DIGITS - 1));
    assign nib  = aval_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        psc_d  = psc_q + 1'b1;
        idx_d  = idx_q;
        pval_d = pval_q;
        pblk_d = pblk_q;
        pend_d = pend_q;
        aval_d = aval_q;
        ablk_d = ablk_q;
        seg_d  = 7'h7F;
        an_d   = '1;
`ifdef SEVEN_SEG_SCANNER_DP_EN
        pdp_d  = pdp_q;
        adp_d  = adp_q;
        dpn_d  = 1'b1;
`endif
        if (tick) begin
            psc_d = '0;
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // Commit reads the pre-edge pending regs; a load on the same edge re-arms pending.
        if (wrap && pend_q) begin
            aval_d = pval_q;
            ablk_d = pblk_q;
            pend_d = 1'b0;
`ifdef SEVEN_SEG_SCANNER_DP_EN
            adp_d  = pdp_q;
`endif
        end
        if (bus.load) begin
            pval_d = bus.value;
            pblk_d = bus.blank;
            pend_d = 1'b1;
`ifdef SEVEN_SEG_SCANNER_DP_EN
            pdp_d  = bus.dp;
`endif
        end
        if (!ablk_q[idx_q]) begin
            seg_d        = decode(nib);
            an_d[idx_q]  = 1'b0;
`ifdef SEVEN_SEG_SCANNER_DP_EN
            dpn_d        = ~adp_q[idx_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q  <= '0;
            idx_q  <= '0;
            pval_q <= '0;
            pblk_q <= '0;
            pend_q <= 1'b0;
            aval_q <= '0;
            ablk_q <= '0;
            seg_q  <= 7'h7F;
            an_q   <= '1;
            fd_q   <= 1'b0;
`ifdef SEVEN_SEG_SCANNER_DP_EN
            pdp_q  <= '0;
            adp_q  <= '0;
            dpn_q  <= 1'b1;
`endif
        end else begin
            psc_q  <= psc_d;
            idx_q  <= idx_d;
            pval_q <= pval_d;
            pblk_q <= pblk_d;
            pend_q <= pend_d;
            aval_q <= aval_d;
            ablk_q <= ablk_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            fd_q   <= wrap;
`ifdef SEVEN_SEG_SCANNER_DP_EN
            pdp_q  <= pdp_d;
            adp_q  <= adp_d;
            dpn_q  <= dpn_d;
`endif
        end
    end

    assign bus.seven_seg  = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pend_q;
`ifdef SEVEN_SEG_SCANNER_DP_EN
    assign bus.dp_n       = dpn_q;
`endif
endmodule
